mem_access_ctrl: RTL and testbench

//  Bus master (initiator) for the MainMemory responder. Takes read/write requests from the

---
 rtl/mem_access_ctrl_if.sv | 29 ++
 rtl/mem_access_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/response channel between the control unit (master) and the memory
// access controller (slave): valid/ready request in, valid/ready response beats out.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_len;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Bus master for MainMemory: accepts single-word writes and 1-4 word read bursts,
// hides the memory's registered read latency and returns one response beat per word.
module mem_access_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_DEPTH  = 16384,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int                LAT_W     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, WR, RSP} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mbr;
  logic [1:0]        beats;
  logic [LAT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              last_q;
  logic              err_q;

  logic accept;
  logic addr_oob;
  logic wait_done;

  assign bus.req_ready = (state == IDLE) & reset;
  assign accept        = bus.req_valid & bus.req_ready;
  // Compare one bit wider so a depth equal to 2**ADDR_W does not wrap to zero.
  assign addr_oob      = {1'b0, bus.req_addr} >= DEPTH_EXT;
  assign wait_done     = (wait_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets its default before the case, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (addr_oob)           state_next = RSP;
          else if (bus.req_write) state_next = WR;
          else                    state_next = RD_ADDR;
        end
      end
      RD_ADDR: state_next = RD_WAIT;
      RD_WAIT: if (wait_done) state_next = RSP;
      WR:      state_next = RSP;
      RSP: begin
        if (bus.rsp_ready) state_next = last_q ? IDLE : RD_ADDR;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the datapath is reset as well because MAR/MBR and the response fields are visible on ports.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mar      <= '0;
      mbr      <= '0;
      beats    <= '0;
      wait_cnt <= '0;
      rdata_q  <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mar   <= bus.req_addr;
            mbr   <= bus.req_wdata;
            beats <= bus.req_write ? 2'd0 : bus.req_len;
            if (addr_oob) begin
              rdata_q <= '0;
              last_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        RD_ADDR: wait_cnt <= LAT_W'(RD_LATENCY - 1);
        RD_WAIT: begin
          if (wait_done) begin
            rdata_q <= mem_data_out;
            last_q  <= (beats == 2'd0);
            err_q   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - LAT_W'(1);
          end
        end
        WR: begin
          rdata_q <= '0;
          last_q  <= 1'b1;
          err_q   <= 1'b0;
        end
        RSP: begin
          // Bursts wrap at the top of the implemented memory without flagging an error.
          if (bus.rsp_ready && !last_q) begin
            mar   <= (mar == LAST_ADDR) ? '0 : mar + ADDR_W'(1);
            beats <= beats - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr         = mar;
  assign mem_data_in      = mbr;
  assign mem_write_enable = (state == WR);
  assign busy             = (state != IDLE);

  assign bus.rsp_valid = (state == RSP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_last  = last_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl with a MainMemory model and
// a word-array reference model of the expected response beats.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16384;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_data_out;
  logic              busy;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH), .RD_LATENCY(1)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .mem_addr         (mem_addr),
    .mem_data_in      (mem_data_in),
    .mem_write_enable (mem_write_enable),
    .mem_data_out     (mem_data_out),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // MainMemory model: synchronous write, one-cycle registered read.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_init = 1'b1;
  int                cyc     = 0;
  int                we_cnt  = 0;

  function automatic logic [15:0] init_word(input int i);
    return 16'(i) ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_enable) we_cnt <= we_cnt + 1;
    if (do_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (mem_write_enable) begin
      mem[mem_addr[13:0]] <= mem_data_in;
    end
    mem_data_out <= mem[mem_addr[13:0]];
  end

  // Reference model: expected memory contents, one word per address.
  logic [15:0] ref_mem [DEPTH];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one request and consume all its beats. stall>0 holds rsp_ready low that many
  // cycles on every beat; junk keeps req_valid high with a write while the controller is busy.
  task automatic run_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [1:0] len, input int stall, input logic junk);
    int          n;
    logic [15:0] exp_d [4];
    logic [15:0] exp_a [4];
    logic        exp_last [4];
    logic        exp_err [4];
    int          exp_we;
    int          we0, acc, prev, t;
    logic [15:0] held;
    logic        is_read;

    is_read = 1'b0;
    exp_we  = 0;
    if (int'(addr) >= DEPTH) begin
      n = 1; exp_d[0] = '0; exp_a[0] = addr; exp_last[0] = 1'b1; exp_err[0] = 1'b1;
    end else if (wr) begin
      n = 1; exp_d[0] = '0; exp_a[0] = addr; exp_last[0] = 1'b1; exp_err[0] = 1'b0;
      ref_mem[addr] = wd;
      exp_we = 1;
    end else begin
      is_read = 1'b1;
      n = int'(len) + 1;
      for (int i = 0; i < n; i++) begin
        exp_a[i]    = 16'((int'(addr) + i) % DEPTH);
        exp_d[i]    = ref_mem[exp_a[i]];
        exp_last[i] = (i == n - 1);
        exp_err[i]  = 1'b0;
      end
    end

    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_len   = len;
    bus.rsp_ready = (stall == 0);
    we0 = we_cnt;
    @(negedge clk);
    acc  = cyc;
    prev = cyc;
    if (junk) begin
      bus.req_write = 1'b1;
      bus.req_addr  = 16'h0020;
      bus.req_wdata = 16'hDEAD;
    end else begin
      bus.req_valid = 1'b0;
    end

    for (int b = 0; b < n; b++) begin
      t = 0;
      while (!bus.rsp_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!bus.rsp_valid) begin
        check("rsp_timeout", 0, 1);
        break;
      end
      check("rsp_rdata", bus.rsp_rdata, exp_d[b]);
      check("rsp_last", bus.rsp_last, exp_last[b]);
      check("rsp_err", bus.rsp_err, exp_err[b]);
      check("beat_addr", mem_addr, exp_a[b]);
      if (is_read && b == 0) check("first_beat_latency", cyc - acc, 2);
      if (is_read && b > 0 && stall == 0) check("beat_period", cyc - prev, 3);
      prev = cyc;
      if (stall > 0) begin
        held = bus.rsp_rdata;
        repeat (stall) begin
          @(negedge clk);
          check("stall_valid", bus.rsp_valid, 1);
          check("stall_rdata", bus.rsp_rdata, held);
          check("stall_mar", mem_addr, exp_a[b]);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check("idle_after_last", {busy, bus.req_ready, bus.rsp_valid}, 3'b010);
    check("write_pulses", we_cnt - we0, exp_we);
  endtask

  initial begin
    int          sel;
    logic        wr;
    logic [15:0] addr;
    int          we0;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_len   = '0;
    bus.rsp_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    do_init = 1'b0;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_outputs", {busy, bus.rsp_valid, bus.rsp_last, bus.rsp_err, mem_write_enable},
          5'b0);
    check("rst_mar_mbr_rdata", {mem_addr, mem_data_in, bus.rsp_rdata}, 48'h0);
    reset = 1'b1;
    @(negedge clk);
    check("req_ready_after_release", bus.req_ready, 1);

    // Write then read back one word.
    run_req(1'b1, 16'h0010, 16'hBEEF, 2'd0, 0, 1'b0);
    run_req(1'b0, 16'h0010, 16'h0000, 2'd0, 0, 1'b0);

    // Preload four words and burst them back with rsp_ready tied high.
    for (int i = 0; i < 4; i++) run_req(1'b1, 16'(16'h0100 + i), 16'(i + 1), 2'd0, 0, 1'b0);
    run_req(1'b0, 16'h0100, 16'h0000, 2'd3, 0, 1'b0);

    // Burst across the top of memory.
    run_req(1'b0, 16'h3FFE, 16'h0000, 2'd3, 0, 1'b0);

    // Out-of-range accesses, then confirm the aliased location is untouched.
    run_req(1'b1, 16'h4000, 16'h1234, 2'd0, 0, 1'b0);
    run_req(1'b0, 16'h4000, 16'h0000, 2'd2, 0, 1'b0);
    run_req(1'b0, 16'h0000, 16'h0000, 2'd0, 0, 1'b0);

    // Stalled burst while a write request is held pending on the request channel.
    run_req(1'b0, 16'h0100, 16'h0000, 2'd3, 5, 1'b1);
    run_req(1'b0, 16'h0020, 16'h0000, 2'd0, 0, 1'b0);

    // Reset during RD_WAIT of a burst.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0100;
    bus.req_len   = 2'd3;
    bus.rsp_ready = 1'b1;
    we0 = we_cnt;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {busy, bus.rsp_valid, bus.rsp_last, bus.rsp_err, mem_write_enable,
                             bus.req_ready}, 6'b0);
    check("midrst_mar_mbr_rdata", {mem_addr, mem_data_in, bus.rsp_rdata}, 48'h0);
    reset = 1'b1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", bus.req_ready, 1);
    check("midrst_no_write", we_cnt - we0, 0);
    run_req(1'b0, 16'h0101, 16'h0000, 2'd1, 0, 1'b0);

    // Randomized mix of reads, writes, out-of-range and wrapping accesses.
    for (int k = 0; k < 40; k++) begin
      wr  = ($urandom_range(0, 9) < 4);
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = 16'(16'h4000 + $urandom_range(0, 16'hBFFF));
      else if (sel == 1) addr = 16'(16'h3FFC + $urandom_range(0, 3));
      else               addr = 16'($urandom_range(0, 63));
      run_req(wr, addr, 16'($urandom), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end
endmodule
